// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage and its matmul engine.
// Holds the matmul FSM state enum and the A/B/C layout and cycle-count constants.
package mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_STORE,
        S_DONE
    } mm_state_t;

    // Operand layout relative to the base address
    localparam int MM_OFF_B    = 4;
    localparam int MM_OFF_C    = 8;

    // Cycle counts for the LOAD and COMPUTE/STORE phases
    localparam int MM_LOAD_CYC = 8;
    localparam int MM_ELEM     = 4;

endpackage

// File: rtl/matmul_engine.sv
// 2x2 byte-matrix multiply engine: FSM, operand/result registers and one 2-term MAC.
// Ports: clk/reset, i_start + latched fields in, memory port (o_addr/o_we/o_wdata,
// i_rdata), o_stall/o_busy/o_done status, o_c0 and latched fields out on DONE.
module matmul_engine
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [7:0]        i_rdata,
    input  logic [2:0]        i_destreg,
    input  logic [7:0]        i_pcplus1,
    input  logic              i_resultsrc,
    output logic              o_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_wdata,
    output logic [7:0]        o_c0,
    output logic [2:0]        o_destreg,
    output logic [7:0]        o_pcplus1,
    output logic              o_resultsrc
);

    mm_state_t         r_state;
    mm_state_t         w_next;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [7:0]        r_op [8];
    logic [7:0]        r_c  [4];
    logic [2:0]        r_destreg;
    logic [7:0]        r_pcplus1;
    logic              r_resultsrc;

    logic [1:0]        w_k;
    logic [7:0]        w_a0;
    logic [7:0]        w_a1;
    logic [7:0]        w_b0;
    logic [7:0]        w_b1;
    logic [7:0]        w_mac;

    // Element k = {i, j}: row i of A (op 2i, 2i+1), column j of B (op 4+j, 6+j)
    assign w_k   = r_cnt[1:0];
    assign w_a0  = r_op[{1'b0, w_k[1], 1'b0}];
    assign w_a1  = r_op[{1'b0, w_k[1], 1'b1}];
    assign w_b0  = r_op[3'(MM_OFF_B) + {2'b00, w_k[0]}];
    assign w_b1  = r_op[3'(MM_OFF_B) + 3'd2 + {2'b00, w_k[0]}];
    assign w_mac = w_a0 * w_b0 + w_a1 * w_b1;

    assign o_c0        = r_c[0];
    assign o_destreg   = r_destreg;
    assign o_pcplus1   = r_pcplus1;
    assign o_resultsrc = r_resultsrc;

    always_comb begin
        w_next  = r_state;
        o_stall = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        o_we    = 1'b0;
        o_addr  = r_base + ADDR_W'(r_cnt);
        o_wdata = r_c[w_k];
        case (r_state)
            S_IDLE: begin
                // Stall in the accept cycle so EX/MEM holds the instruction
                if (i_start) begin
                    o_stall = 1'b1;
                    w_next  = S_LOAD;
                end
            end
            S_LOAD: begin
                o_stall = 1'b1;
                o_busy  = 1'b1;
                if (r_cnt == 3'(MM_LOAD_CYC - 1)) w_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                o_stall = 1'b1;
                o_busy  = 1'b1;
                if (r_cnt == 3'(MM_ELEM - 1)) w_next = S_STORE;
            end
            S_STORE: begin
                o_stall = 1'b1;
                o_busy  = 1'b1;
                o_we    = 1'b1;
                o_addr  = r_base + ADDR_W'(MM_OFF_C) + ADDR_W'(r_cnt);
                if (r_cnt == 3'(MM_ELEM - 1)) w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_base      <= '0;
            r_destreg   <= '0;
            r_pcplus1   <= '0;
            r_resultsrc <= 1'b0;
            for (int i = 0; i < 8; i++) r_op[i] <= '0;
            for (int i = 0; i < 4; i++) r_c[i] <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || r_state == S_IDLE) r_cnt <= '0;
            else r_cnt <= r_cnt + 3'd1;
            if (r_state == S_IDLE && i_start) begin
                r_base      <= i_base;
                r_destreg   <= i_destreg;
                r_pcplus1   <= i_pcplus1;
                r_resultsrc <= i_resultsrc;
            end
            if (r_state == S_LOAD) r_op[r_cnt] <= i_rdata;
            if (r_state == S_COMPUTE) r_c[w_k] <= w_mac;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: 2^ADDR_W-byte data memory, zero-latency loads/stores, and
// the optional 2x2 matmul instruction (built only when MEM_MATMUL_EN is defined).
// Ports: clk, reset (sync, high); EX/MEM inputs ALUResult, WriteData, pcplus1,
// destreg, RegWrite, ResultSrc, MemWrite, is_matrix_mult; MEM/WB outputs
// ReadData, ALUResult_out, pcplus1_out, destreg_out, RegWrite_out,
// ResultSrc_out, is_matrix_mult_out; stall freezes the upstream pipeline.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ALUResult,
    input  logic [7:0] WriteData,
    input  logic [7:0] pcplus1,
    input  logic [2:0] destreg,
    input  logic       RegWrite,
    input  logic       ResultSrc,
    input  logic       MemWrite,
    input  logic       is_matrix_mult,
    output logic [7:0] ReadData,
    output logic [7:0] ALUResult_out,
    output logic [7:0] pcplus1_out,
    output logic [2:0] destreg_out,
    output logic       RegWrite_out,
    output logic       ResultSrc_out,
    output logic       is_matrix_mult_out,
    output logic       stall
);

    logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic [7:0]        w_wdata;
    logic [7:0]        w_rdata;
    logic              w_stall;
    logic              w_done;
    logic              w_eng_own;
    logic              w_bubble;

    logic              w_eng_stall;
    logic              w_eng_busy;
    logic              w_eng_done;
    logic              w_eng_we;
    logic [ADDR_W-1:0] w_eng_addr;
    logic [7:0]        w_eng_wdata;
    logic [7:0]        w_c0;
    logic [2:0]        w_dst_l;
    logic [7:0]        w_pc_l;
    logic              w_rs_l;

`ifdef MEM_MATMUL_EN
    matmul_engine #(
        .ADDR_W(ADDR_W)
    ) u_engine (
        .clk        (clk),
        .reset      (reset),
        .i_start    (is_matrix_mult & ~reset),
        .i_base     (ADDR_W'(ALUResult)),
        .i_rdata    (w_rdata),
        .i_destreg  (destreg),
        .i_pcplus1  (pcplus1),
        .i_resultsrc(ResultSrc),
        .o_stall    (w_eng_stall),
        .o_busy     (w_eng_busy),
        .o_done     (w_eng_done),
        .o_we       (w_eng_we),
        .o_addr     (w_eng_addr),
        .o_wdata    (w_eng_wdata),
        .o_c0       (w_c0),
        .o_destreg  (w_dst_l),
        .o_pcplus1  (w_pc_l),
        .o_resultsrc(w_rs_l)
    );
`else
    assign w_eng_stall = 1'b0;
    assign w_eng_busy  = 1'b0;
    assign w_eng_done  = 1'b0;
    assign w_eng_we    = 1'b0;
    assign w_eng_addr  = '0;
    assign w_eng_wdata = '0;
    assign w_c0        = '0;
    assign w_dst_l     = '0;
    assign w_pc_l      = '0;
    assign w_rs_l      = 1'b0;
`endif

    // Reset aborts the engine in the same cycle: no stall, no engine writes
    assign w_stall   = w_eng_stall & ~reset;
    assign w_done    = w_eng_done & ~reset;
    assign w_eng_own = w_eng_busy & ~reset;
    assign w_bubble  = reset | w_stall;

    assign w_addr  = w_eng_own ? w_eng_addr : ADDR_W'(ALUResult);
    assign w_we    = w_eng_own ? w_eng_we : (MemWrite & ~w_stall);
    assign w_wdata = w_eng_own ? w_eng_wdata : WriteData;
    assign w_rdata = r_mem[w_addr];

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_addr] <= w_wdata;
    end

    assign stall              = w_stall;
    assign ReadData           = w_done ? w_c0 : w_rdata;
    assign ALUResult_out      = ALUResult;
    assign pcplus1_out        = w_done ? w_pc_l : pcplus1;
    assign destreg_out        = w_done ? w_dst_l : destreg;
    assign ResultSrc_out      = w_done ? w_rs_l : ResultSrc;
    assign RegWrite_out       = RegWrite & ~w_bubble & ~w_done;
    assign is_matrix_mult_out = ~reset & (w_done | (is_matrix_mult & ~w_stall));

endmodule
